gray_timer: RTL
===============

# gray_timer

Parametrised synchronous timer/counter with a single count register of `WIDTH` bits. It counts up or down, reloads either periodically or in one-shot mode, flags terminal count and compare match, and drives a registered Gray-coded or binary count bus. It is the next-generation replacement for the fixed 8-bit cascaded Gray counter in the timer datapath. Its `tc` and `count_triger` outputs feed the same downstream event logic.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits; legal range 2..32.
- `PERIOD_RST`, default 2**WIDTH-1: value of the internal period register after reset.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `en` in 1: count enable; one step per cycle while high.
- `prs` in 1: synchronous preset. Loads `load_val` into the count and re-arms one-shot.
- `load_val` in WIDTH: preset value.
- `per_we` in 1: write strobe for the period register.
- `per_val` in WIDTH: new period value.
- `dir` in 1: 0 = count up, 1 = count down.
- `one_shot` in 1: 0 = periodic reload, 1 = stop at terminal count.
- `cmp_val` in WIDTH: compare value.
- `out` out WIDTH: registered count, Gray-coded or binary (see Configuration).
- `out_bin` out WIDTH: registered binary count.
- `tc` out 1: terminal-count pulse.
- `count_triger` out 1: compare-match pulse.
- `running` out 1: 0 when halted in one-shot mode.

## Operation
- Internal state: binary `cnt`, `period` register, `running` flag, plus registered `tc` and `count_triger`.
- Priority per edge: `clr` > `prs` > `en`.
- `per_we` is independent of that priority except for `clr`, which wins. It writes `period <= per_val`.
- Reset values (`clr`=1):
  - `cnt`=0, `out`=0, `out_bin`=0
  - `period`=`PERIOD_RST`
  - `running`=1
  - `tc`=0, `count_triger`=0
- Preset (`prs`=1, `clr`=0): `cnt <= load_val`, `running <= 1`. No `tc` or `count_triger` pulse results from a preset, even if `load_val` equals `cmp_val` or the terminal value.
- Step (`en`=1, `running`=1, no `clr`/`prs`):
  - Up, `cnt`==`period`:
    - terminal event.
    - Next `cnt` = 0 if periodic; if one-shot, `cnt` holds at `period` and `running <= 0`.
  - Up, otherwise: `cnt <= cnt+1` modulo 2**WIDTH.
    - If `cnt` > `period` (period lowered mid-run), the count wraps naturally from all-ones to 0 with no terminal event.
  - Down, `cnt`==0:
    - terminal event.
    - Next `cnt` = `period` if periodic; if one-shot, `cnt` holds at 0 and `running <= 0`.
  - Down, otherwise: `cnt <= cnt-1`.
- With `running`=0, `en` is ignored. Only `prs` or `clr` restarts the counter.
- Terminal event: `tc` is 1 for exactly the cycle after the edge. Consecutive terminal events give `tc` high on consecutive cycles; for example, `period`=0 in periodic mode gives `tc` high every enabled cycle.
- Compare match: `count_triger` is 1 for the cycle after any step edge whose new `cnt` equals `cmp_val`. This includes a wrap to 0 or a reload to `period`. A one-shot hold step is not a new value and produces no match.
- `dir`, `one_shot` and `cmp_val` are sampled every cycle. A change takes effect on the next step.
- `period` written in the same cycle as a step takes effect on the following step. The current step uses the old `period`.

## Timing
- Latency: 1 cycle from an input sampled at edge N to `out`, `out_bin`, `tc`, `count_triger` and `running` valid after edge N.
- All outputs are registered; there are no combinational input-to-output paths.
- `out` and `out_bin` always describe the same count in the same cycle.
- `tc` and `count_triger` are single-cycle pulses aligned with the first cycle the new count is visible.
- `clr` asserted mid-count clears the pulses on the next edge, even if a terminal event or match would have occurred.

## Configuration
- Macro `GRAY_TIMER_GRAY_OUT_EN`.
- Defined: `out` = Gray code of `cnt`, i.e. `cnt ^ (cnt>>1)`, held in its own register. Exactly one `out` bit toggles per ±1 step.
- Undefined: `out` equals `out_bin`, and the Gray register is not built.
- `out_bin`, `tc` and `count_triger` are identical in both builds.

## Test plan
- Reset, then WIDTH=8, `period`=5, up, periodic, `en`=1: `out_bin` steps 1,2,3,4,5,0. `tc`=1 only in the cycle `out_bin` first shows 0, then repeats every 6 cycles.
- Down, one-shot, `prs` with `load_val`=3, `en`=1: `out_bin` shows 3,2,1,0. `tc` pulses once with 0. `running`=0 and the count holds at 0 while `en` stays high. A second `prs` restarts from 3.
- `cmp_val`=4, up, `period`=9: `count_triger` pulses once per period, in the cycle `out_bin`=4. `prs` with `load_val`=4 produces no pulse.
- `per_we` writes 2 while `cnt`=6 (up, periodic): the count runs 7..255, wraps to 0 with `tc`=0, then counts 1,2,0 with `tc`=1 on that 0.
- `clr`, `prs` and `en` all asserted on the same edge during a terminal step: next cycle `out_bin`=0, `tc`=0, `running`=1.
- With `GRAY_TIMER_GRAY_OUT_EN` defined, a free-running up count over all 256 values: `out` equals `out_bin ^ (out_bin>>1)` every cycle, and the Hamming distance between successive `out` values is 1. Without the macro, `out`==`out_bin`.

Source files
------------

// File: rtl/gray_timer.sv
// ---------------------------------------------------------------------------
// gray_timer
//
// Parametrised up/down timer with periodic or one-shot reload, terminal-count
// and compare-match pulses, and a registered count bus that is either binary
// or Gray-coded.
//
// Build option:
//   GRAY_TIMER_GRAY_OUT_EN  defined   -> out carries the Gray code of the count,
//                                        held in its own register
//                           undefined -> out mirrors out_bin, no Gray register
//
// Parameters:
//   WIDTH       counter width, 2..32
//   PERIOD_RST  period register value after clr (all ones by default)
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   clr           synchronous active-high reset (highest priority)
//   en            count enable, one step per cycle
//   prs           synchronous preset: cnt <= load_val, re-arms one-shot
//   load_val      preset value
//   per_we        period register write strobe
//   per_val       new period value
//   dir           0 = up, 1 = down
//   one_shot      0 = periodic reload, 1 = halt at terminal count
//   cmp_val       compare value
//   out           registered count, Gray or binary depending on the build
//   out_bin       registered binary count
//   tc            terminal-count pulse, one cycle per terminal event
//   count_triger  compare-match pulse, one cycle per matching step
//   running       low while halted in one-shot mode
//
// Run state:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | en advances the count
//   ST_HALT  | one-shot reached terminal count; en ignored until prs or clr
// ---------------------------------------------------------------------------
module gray_timer #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PERIOD_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             prs,
    input  logic [WIDTH-1:0] load_val,
    input  logic             per_we,
    input  logic [WIDTH-1:0] per_val,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_bin,
    output logic             tc,
    output logic             count_triger,
    output logic             running
);

    localparam logic [0:0] ST_HALT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] period;
    logic [0:0]       run_st;
    logic             tc_q;
    logic             trig_q;

    // Step decode
    logic             step;
    logic [WIDTH-1:0] step_cnt;
    logic             term;
    logic             hold;

    // Next-state
    logic [WIDTH-1:0] cnt_d;
    logic [0:0]       run_st_d;
    logic             tc_d;
    logic             trig_d;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign step = en && (run_st == ST_RUN) && !prs;

    // A count above a lowered period never matches cnt==period, so it simply
    // runs up to all-ones and wraps through the +1 path without a terminal event.
    always_comb begin
        step_cnt = cnt;
        term     = 1'b0;
        hold     = 1'b0;
        if (!dir) begin
            if (cnt == period) begin
                term = 1'b1;
                if (one_shot) begin
                    hold     = 1'b1;
                    step_cnt = cnt;
                end else begin
                    step_cnt = '0;
                end
            end else begin
                step_cnt = cnt + WIDTH'(1);
            end
        end else begin
            if (cnt == '0) begin
                term = 1'b1;
                if (one_shot) begin
                    hold     = 1'b1;
                    step_cnt = cnt;
                end else begin
                    step_cnt = period;
                end
            end else begin
                step_cnt = cnt - WIDTH'(1);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt;
        run_st_d = run_st;
        tc_d     = 1'b0;
        trig_d   = 1'b0;
        if (prs) begin
            // Preset never produces a pulse, even when load_val hits cmp_val.
            cnt_d    = load_val;
            run_st_d = ST_RUN;
        end else if (step) begin
            cnt_d  = step_cnt;
            tc_d   = term;
            // A one-shot hold is not a new count value, so it cannot match.
            trig_d = !hold && (step_cnt == cmp_val);
            if (hold) begin
                run_st_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt    <= '0;
            period <= PERIOD_RST;
            run_st <= ST_RUN;
            tc_q   <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            // The current step used the old period; a write lands for the next one.
            if (per_we) begin
                period <= per_val;
            end
            cnt    <= cnt_d;
            run_st <= run_st_d;
            tc_q   <= tc_d;
            trig_q <= trig_d;
        end
    end

`ifdef GRAY_TIMER_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;

    // Encoded from the next count so the Gray bus lines up with out_bin.
    always_ff @(posedge clk) begin
        if (clr) begin
            gray_q <= '0;
        end else begin
            gray_q <= to_gray(cnt_d);
        end
    end

    assign out = gray_q;
`else
    assign out = cnt;
`endif

    assign out_bin      = cnt;
    assign tc           = tc_q;
    assign count_triger = trig_q;
    assign running      = (run_st == ST_RUN);

endmodule
